serdes_word_aligner: RTL and testbench

SERDES_WORD_ALIGNER -- requirements
Module: serdes_word_aligner

---
 rtl/serdes_word_aligner.sv | 101 ++++++++++
 tb/tb_serdes_word_aligner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_word_aligner.sv
// rtl/serdes_word_aligner.sv - 8b/10b symbol aligner locking onto K28.5 commas in a serial bit stream
module serdes_word_aligner #(
  parameter int LOCK_COMMAS = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       Sin,
  output logic [9:0] sym,
  output logic       sym_valid,
  output logic       sym_is_comma,
  output logic       locked,
  output logic       realign
);

  localparam logic [9:0] K28_5_RDN     = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP     = 10'b1100000101;
  localparam logic [3:0] LOCK_N        = 4'(LOCK_COMMAS);
  localparam bit         LOCK_ON_FIRST = (LOCK_COMMAS == 1);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  state_t     state;
  logic [9:0] shreg;
  logic [9:0] shift_next;
  logic [3:0] bitpos;
  logic [3:0] ccnt;
  logic [3:0] ccnt_inc;
  logic       comma;
  logic       boundary;

  // All decisions look at the window including the bit arriving this edge.
  always_comb begin
    shift_next = {shreg[8:0], Sin};
    comma      = (shift_next == K28_5_RDN) || (shift_next == K28_5_RDP);
    boundary   = (bitpos == 4'd9);
    ccnt_inc   = (ccnt < LOCK_N) ? ccnt + 4'd1 : ccnt;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      shreg        <= 10'd0;
      bitpos       <= 4'd0;
      ccnt         <= 4'd0;
      sym          <= 10'd0;
      sym_valid    <= 1'b0;
      sym_is_comma <= 1'b0;
      locked       <= 1'b0;
      realign      <= 1'b0;
    end else begin
      shreg        <= shift_next;
      bitpos       <= boundary ? 4'd0 : bitpos + 4'd1;
      sym_valid    <= 1'b0;
      sym_is_comma <= 1'b0;
      realign      <= 1'b0;
      case (state)
        HUNT: begin
          if (comma) begin
            bitpos       <= 4'd0;
            ccnt         <= 4'd1;
            sym          <= shift_next;
            sym_valid    <= 1'b1;
            sym_is_comma <= 1'b1;
            state        <= LOCK_ON_FIRST ? LOCKED : CHECK;
            locked       <= LOCK_ON_FIRST;
          end
        end
        CHECK, LOCKED: begin
          if (boundary) begin
            sym          <= shift_next;
            sym_valid    <= 1'b1;
            sym_is_comma <= comma;
            if (state == CHECK && comma) begin
              ccnt <= ccnt_inc;
              if (ccnt_inc == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end else if (comma) begin
            // A comma off the current grid re-anchors the symbol boundary.
            bitpos       <= 4'd0;
            ccnt         <= 4'd1;
            sym          <= shift_next;
            sym_valid    <= 1'b1;
            sym_is_comma <= 1'b1;
            realign      <= 1'b1;
            state        <= LOCK_ON_FIRST ? LOCKED : CHECK;
            locked       <= LOCK_ON_FIRST;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_word_aligner.sv
// tb/tb_serdes_word_aligner.sv - self-checking bench for serdes_word_aligner (LOCK_COMMAS 3 and 1)
module tb_serdes_word_aligner;

  localparam logic [9:0] K_RDN = 10'h0FA;
  localparam logic [9:0] K_RDP = 10'h305;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic [9:0] sym0, sym1;
  logic       v0, v1, c0, c1, l0, l1, r0, r1;

  always #10 clk = ~clk;

  serdes_word_aligner #(.LOCK_COMMAS(3)) dut (
    .CLOCK_50(clk), .reset(rst), .Sin(sin), .sym(sym0), .sym_valid(v0),
    .sym_is_comma(c0), .locked(l0), .realign(r0)
  );

  serdes_word_aligner #(.LOCK_COMMAS(1)) dut1 (
    .CLOCK_50(clk), .reset(rst), .Sin(sin), .sym(sym1), .sym_valid(v1),
    .sym_is_comma(c1), .locked(l1), .realign(r1)
  );

  typedef struct {
    logic [9:0] tx;
    logic [9:0] sym;
    logic       comma;
    logic       lock;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model: bit index since reset, index of the anchoring comma, aligned comma count.
  int         lock_req[2] = '{3, 1};
  int         anchor[2];
  int         cnt[2];
  int         bitn;
  logic [9:0] win;
  logic [9:0] e_sym[2];
  logic       e_v[2], e_c[2], e_l[2], e_r[2];

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win  = 10'd0;
    bitn = 0;
    for (int k = 0; k < 2; k++) begin
      anchor[k] = -1;
      cnt[k]    = 0;
      e_sym[k]  = 10'd0;
      e_v[k]    = 1'b0;
      e_c[k]    = 1'b0;
      e_l[k]    = 1'b0;
      e_r[k]    = 1'b0;
    end
  endtask

  task automatic model_step(input logic b);
    logic is_c, ev, rl;
    win  = {win[8:0], b};
    is_c = (win == K_RDN) || (win == K_RDP);
    for (int k = 0; k < 2; k++) begin
      ev = 1'b0;
      rl = 1'b0;
      if (anchor[k] < 0) begin
        if (is_c) begin
          anchor[k] = bitn;
          cnt[k]    = 1;
          ev        = 1'b1;
        end
      end else if ((bitn - anchor[k]) % 10 == 0) begin
        ev = 1'b1;
        if (is_c && cnt[k] < lock_req[k]) cnt[k]++;
      end else if (is_c) begin
        anchor[k] = bitn;
        cnt[k]    = 1;
        ev        = 1'b1;
        rl        = 1'b1;
      end
      e_v[k] = ev;
      e_c[k] = ev && is_c;
      e_r[k] = rl;
      if (ev) e_sym[k] = win;
      e_l[k] = (anchor[k] >= 0) && (cnt[k] >= lock_req[k]);
    end
    bitn++;
  endtask

  task automatic check_all();
    chk("d0 sym", sym0, e_sym[0]);
    chk("d0 sym_valid", v0, e_v[0]);
    chk("d0 sym_is_comma", c0, e_c[0]);
    chk("d0 locked", l0, e_l[0]);
    chk("d0 realign", r0, e_r[0]);
    chk("d1 sym", sym1, e_sym[1]);
    chk("d1 sym_valid", v1, e_v[1]);
    chk("d1 sym_is_comma", c1, e_c[1]);
    chk("d1 locked", l1, e_l[1]);
    chk("d1 realign", r1, e_r[1]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " sym"}, sym0, 10'd0);
    chk({tag, " sym_valid"}, v0, 1'b0);
    chk({tag, " sym_is_comma"}, c0, 1'b0);
    chk({tag, " locked"}, l0, 1'b0);
    chk({tag, " realign"}, r0, 1'b0);
    chk({tag, " d1 locked"}, l1, 1'b0);
    chk({tag, " d1 sym_valid"}, v1, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
    model_step(b);
    check_all();
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) send_bit(s[i]);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    vecs[0] = '{10'h2AA, 10'h2AA, 1'b0, 1'b1};
    vecs[1] = '{K_RDN,   K_RDN,   1'b1, 1'b1};
    vecs[2] = '{10'h155, 10'h155, 1'b0, 1'b1};
    vecs[3] = '{K_RDP,   K_RDP,   1'b1, 1'b1};
    vecs[4] = '{10'h2AA, 10'h2AA, 1'b0, 1'b1};

    rst = 1'b1;
    sin = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Idle line: nothing should happen.
    repeat (50) send_bit(1'b0);

    // Three random bits, then three aligned commas.
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    send_sym(K_RDN);
    chk("c1 valid", v0, 1'b1);
    chk("c1 sym", sym0, K_RDN);
    chk("c1 comma", c0, 1'b1);
    chk("c1 locked", l0, 1'b0);
    chk("lc1 locked", l1, 1'b1);
    chk("lc1 valid", v1, 1'b1);
    send_sym(K_RDP);
    chk("c2 sym", sym0, K_RDP);
    chk("c2 locked", l0, 1'b0);
    send_sym(K_RDN);
    chk("c3 sym", sym0, K_RDN);
    chk("c3 valid", v0, 1'b1);
    chk("c3 locked", l0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      send_sym(vecs[i].tx);
      chk($sformatf("tbl%0d valid", i), v0, 1'b1);
      chk($sformatf("tbl%0d sym", i), sym0, vecs[i].sym);
      chk($sformatf("tbl%0d comma", i), c0, vecs[i].comma);
      chk($sformatf("tbl%0d locked", i), l0, vecs[i].lock);
      chk($sformatf("tbl%0d realign", i), r0, 1'b0);
    end

    // One slipped bit, then a comma on the new phase.
    send_bit(1'b0);
    send_sym(K_RDN);
    chk("slip realign", r0, 1'b1);
    chk("slip valid", v0, 1'b1);
    chk("slip sym", sym0, K_RDN);
    chk("slip locked", l0, 1'b0);
    send_sym(K_RDN);
    chk("slip c2 locked", l0, 1'b0);
    chk("slip c2 realign", r0, 1'b0);
    send_sym(K_RDP);
    chk("slip c3 locked", l0, 1'b1);

    // Reset four bits into a data symbol, then relock from scratch.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset("midsym");
    send_sym(K_RDN);
    chk("relock1", l0, 1'b0);
    send_sym(K_RDP);
    chk("relock2", l0, 1'b0);
    send_sym(K_RDN);
    chk("relock3", l0, 1'b1);

    // Random traffic with commas at arbitrary phases and occasional resets.
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        send_sym($urandom_range(0, 1) ? K_RDN : K_RDP);
      end else if (r < 9) begin
        repeat ($urandom_range(1, 12)) send_bit(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 7) == 0) begin
        do_reset("rnd");
      end else begin
        send_sym(10'($urandom_range(0, 1023)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
